// File: rtl/image_mem_pkg.sv
// rtl/image_mem_pkg.sv - shared defaults and clear-FSM encoding for the image memory
// Purpose: default geometry/init value and the clear-sequencer state type.
// Contents: A_W_DEF, D_W_DEF, INIT_VAL_DEF, clr_state_t (IDLE=0, CLEAR=1).
package image_mem_pkg;

  localparam int A_W_DEF      = 5;
  localparam int D_W_DEF      = 1;
  localparam int INIT_VAL_DEF = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/image_mem_clr_seq.sv
// rtl/image_mem_clr_seq.sv - clear sweep sequencer (FSM plus address counter)
// Purpose: on reset or an idle clr pulse, emit one INIT write per cycle over 0..DEPTH-1.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset, (re)starts the sweep at address 0
//   clr      in   start pulse, honoured only in IDLE
//   busy     out  sweep in progress
//   clr_we   out  sweep write strobe for this cycle
//   clr_addr out  sweep write address for this cycle
module image_mem_clr_seq
  import image_mem_pkg::*;
#(
  parameter int A_W   = A_W_DEF,
  parameter int DEPTH = 2 ** A_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  output logic           busy,
  output logic           clr_we,
  output logic [A_W-1:0] clr_addr
);

  localparam logic [A_W-1:0] LAST = A_W'(DEPTH - 1);

  clr_state_t     state, state_n;
  logic [A_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy    = 1'b0;
    clr_we  = 1'b0;
    case (state)
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          cnt_n   = '0;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt == LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/image_memory_dp.sv
// rtl/image_memory_dp.sv - dual-port image memory with clear sweep and collision flag
// Purpose: DEPTH x D_W store; port 0 writes on the request edge, port 1 one edge later;
//          registered read-first reads; clear sweep has priority, port 0 beats port 1.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   A_0, DI_0, WE_0   port 0 address / write data / write enable
//   DQ_0              port 0 registered read data
//   A_1, DI_1, WE_1   port 1 address / write data / write request (committed next edge)
//   DQ_1              port 1 registered read data
//   CLR               clear sweep start pulse
//   BUSY              clear sweep in progress
//   COLL              one-cycle pulse: same-address write collision on the previous edge
module image_memory_dp
  import image_mem_pkg::*;
#(
  parameter int             A_W      = A_W_DEF,
  parameter int             D_W      = D_W_DEF,
  parameter int             DEPTH    = 2 ** A_W,
  parameter logic [D_W-1:0] INIT_VAL = D_W'(INIT_VAL_DEF)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [A_W-1:0] A_0,
  input  logic [D_W-1:0] DI_0,
  input  logic           WE_0,
  output logic [D_W-1:0] DQ_0,
  input  logic [A_W-1:0] A_1,
  input  logic [D_W-1:0] DI_1,
  input  logic           WE_1,
  output logic [D_W-1:0] DQ_1,
  input  logic           CLR,
  output logic           BUSY,
  output logic           COLL
);

  localparam logic [A_W:0] DEPTH_L = (A_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [A_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [D_W-1:0] mem [DEPTH];

  logic           busy, clr_we;
  logic [A_W-1:0] clr_addr;

  logic           st_valid;
  logic [A_W-1:0] st_addr;
  logic [D_W-1:0] st_data;

  logic start, p0_wr, hit, p1_wr;

  image_mem_clr_seq #(.A_W(A_W), .DEPTH(DEPTH)) u_clr_seq (
    .clk      (CLK),
    .rst      (RST),
    .clr      (CLR),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // start marks the edge on which BUSY rises from a CLR pulse; reads and
  // port-1 capture are already suppressed on that edge.
  assign start = CLR && !busy;
  assign p0_wr = WE_0 && !busy && in_range(A_0);
  assign hit   = p0_wr && st_valid && (st_addr == A_0);
  assign p1_wr = st_valid && !busy && !hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_valid <= 1'b0;
      st_addr  <= '0;
      st_data  <= '0;
    end else begin
      st_valid <= WE_1 && !busy && !CLR && in_range(A_1);
      st_addr  <= A_1;
      st_data  <= DI_1;
    end
  end

  // No reset on the array itself; the sweep that reset launches initialises it.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (clr_we) begin
        mem[clr_addr] <= INIT_VAL;
      end else begin
        if (p0_wr) mem[A_0] <= DI_0;
        if (p1_wr) mem[st_addr] <= st_data;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || busy || start) begin
      DQ_0 <= '0;
      DQ_1 <= '0;
    end else begin
      DQ_0 <= in_range(A_0) ? mem[A_0] : '0;
      DQ_1 <= in_range(A_1) ? mem[A_1] : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) COLL <= 1'b0;
    else     COLL <= hit;
  end

  assign BUSY = busy;

endmodule

// File: tb/tb_image_memory_dp.sv
// tb/tb_image_memory_dp.sv - randomized and directed bench for image_memory_dp
module tb_image_memory_dp;

  localparam int             A_W   = 5;
  localparam int             D_W   = 8;
  localparam int             DEPTH = 32;
  localparam logic [D_W-1:0] INIT  = 8'hA5;

  logic           clk = 1'b0;
  logic           rst, clr, we0, we1;
  logic [A_W-1:0] a0, a1;
  logic [D_W-1:0] di0, di1;
  logic [D_W-1:0] dq0, dq1;
  logic           busy, coll;

  always #5 clk = ~clk;

  image_memory_dp #(.A_W(A_W), .D_W(D_W), .DEPTH(DEPTH), .INIT_VAL(INIT)) dut (
    .CLK  (clk),
    .RST  (rst),
    .A_0  (a0),
    .DI_0 (di0),
    .WE_0 (we0),
    .DQ_0 (dq0),
    .A_1  (a1),
    .DI_1 (di1),
    .WE_1 (we1),
    .DQ_1 (dq1),
    .CLR  (clr),
    .BUSY (busy),
    .COLL (coll)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory image, words of sweep still to write, pending port-1 word.
  logic [D_W-1:0] m [DEPTH];
  int             left = DEPTH;
  bit             pv = 0;
  logic [A_W-1:0] pa;
  logic [D_W-1:0] pd;
  logic [D_W-1:0] e_dq0 = '0, e_dq1 = '0;
  bit             e_coll = 0;

  function automatic void model_edge();
    bit was_busy, starting, p0;
    if (rst) begin
      left = DEPTH; pv = 0; e_dq0 = '0; e_dq1 = '0; e_coll = 0;
      return;
    end
    was_busy = (left > 0);
    starting = !was_busy && clr;
    e_dq0  = (was_busy || starting) ? '0 : m[int'(a0)];
    e_dq1  = (was_busy || starting) ? '0 : m[int'(a1)];
    e_coll = 0;
    if (was_busy) begin
      m[DEPTH - left] = INIT;
      left--;
    end else begin
      p0 = we0;
      if (p0) m[int'(a0)] = di0;
      if (pv) begin
        if (p0 && pa == a0) e_coll = 1;
        else m[int'(pa)] = pd;
      end
    end
    pv = !was_busy && !starting && we1;
    pa = a1;
    pd = di1;
    if (starting) left = DEPTH;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("busy", 32'(busy), 32'(left > 0));
    check("dq0", 32'(dq0), 32'(e_dq0));
    check("dq1", 32'(dq1), 32'(e_dq1));
    check("coll", 32'(coll), 32'(e_coll));
  endtask

  // Returns the number of edges until BUSY is seen low, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      tick();
      n = i;
      if (!busy) break;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
    rst = 1; clr = 0; we0 = 0; we1 = 0; a0 = '0; a1 = '0; di0 = '0; di1 = '0;

    // Reset, then the initial sweep.
    tick(); tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_dq0", 32'(dq0), 32'd0);
    check("rst_coll", 32'(coll), 32'd0);
    rst = 0;
    wait_idle(n);
    check("reset_sweep_len", 32'(n), 32'd32);
    a0 = 5'd0; a1 = 5'd17;
    tick();
    check("init_rd0", 32'(dq0), 32'hA5);
    check("init_rd17", 32'(dq1), 32'hA5);
    a0 = 5'd31;
    tick();
    check("init_rd31", 32'(dq0), 32'hA5);

    // Port-0 write with same-cycle read of the same address.
    a0 = 5'd5; di0 = 8'h3C; we0 = 1;
    tick();
    check("p0_read_first", 32'(dq0), 32'hA5);
    we0 = 0;
    tick();
    check("p0_new", 32'(dq0), 32'h3C);

    // Port-1 write visibility.
    a1 = 5'd9; di1 = 8'h7E; we1 = 1; a0 = 5'd9;
    tick();
    we1 = 0;
    tick();
    check("p1_old_n1", 32'(dq0), 32'hA5);
    tick();
    check("p1_new_n2", 32'(dq0), 32'h7E);

    // Collision on address 12: port 0 wins, COLL for one cycle.
    a1 = 5'd12; di1 = 8'h11; we1 = 1;
    tick();
    we1 = 0; a0 = 5'd12; di0 = 8'h22; we0 = 1;
    tick();
    check("coll_set", 32'(coll), 32'd1);
    we0 = 0;
    tick();
    check("coll_clear", 32'(coll), 32'd0);
    check("coll_winner", 32'(dq0), 32'h22);

    // Same stimulus, different addresses: both land, no COLL.
    a1 = 5'd12; di1 = 8'h11; we1 = 1;
    tick();
    we1 = 0; a0 = 5'd13; di0 = 8'h22; we0 = 1;
    tick();
    check("nocoll", 32'(coll), 32'd0);
    we0 = 0; a0 = 5'd12; a1 = 5'd13;
    tick();
    check("both_p1", 32'(dq0), 32'h11);
    check("both_p0", 32'(dq1), 32'h22);
    check("nocoll2", 32'(coll), 32'd0);

    // CLR sweep with a write attempted mid-sweep and a second CLR while busy.
    clr = 1;
    tick();
    check("clr_busy_rise", 32'(busy), 32'd1);
    clr = 0;
    n = 0;
    for (int i = 1; i <= 3 * DEPTH; i++) begin
      we0 = (i == 5); a0 = 5'd3; di0 = 8'h5A;
      clr = (i == 8);
      tick();
      n = i;
      if (!busy) break;
    end
    we0 = 0; clr = 0;
    check("clr_sweep_len", 32'(n), 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      a0 = 5'(i); a1 = 5'(DEPTH - 1 - i);
      tick();
      check("clr_word", 32'(dq0), 32'hA5);
    end

    // Pending port-1 write discarded by RST.
    a1 = 5'd20; di1 = 8'h99; we1 = 1;
    tick();
    we1 = 0; rst = 1;
    tick();
    rst = 0;
    wait_idle(n);
    a0 = 5'd20;
    tick();
    check("pend_dropped", 32'(dq0), 32'hA5);

    // RST at sweep cycle 10 restarts a full sweep.
    clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1;
    tick();
    rst = 0;
    wait_idle(n);
    check("rst_mid_sweep_len", 32'(n), 32'd32);

    // Randomized traffic on a small address window to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      a0  = 5'($urandom_range(0, 7));
      a1  = 5'($urandom_range(0, 7));
      di0 = 8'($urandom);
      di1 = 8'($urandom);
      clr = ($urandom_range(0, 79) == 0);
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; clr = 0; we0 = 0; we1 = 0;
    wait_idle(n);
    for (int i = 0; i < DEPTH; i++) begin
      a0 = 5'(i); a1 = 5'(i);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
